ball_swarm: RTL and testbench

//  Next-generation bullet engine for the fighting box. Animates N_BALLS independent balls, each with
//  its own signed X/Y velocity and active flag, and a per-axis bounce or wrap mode. Balls are loaded
//  at runtime through a ready/valid port. One ball is updated per clock in a sweep started by each

---
 rtl/ball_swarm.sv | 243 ++++++++++++++++++++++++
 tb/tb_ball_swarm.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ball_swarm.sv
`default_nettype none
// ============================================================================
//  Module      : ball_swarm
//  Description : Multi-ball bullet engine. One ball per clock is moved (bounce
//                or wrap per axis) in a sweep launched by the animation strobe,
//                and every active ball is box-tested against the heart.
//  Revision    : 1.0 - initial release
// ============================================================================
module ball_swarm #(
    parameter int N_BALLS  = 4,
    parameter int W        = 16,
    parameter int VW       = 4,
    parameter int F_WIDTH  = 150,
    parameter int F_HEIGHT = 150,
    parameter int FX       = 245,
    parameter int FY       = 230,
    parameter int R        = 5,
    parameter bit X_WRAP   = 1'b0,
    parameter bit Y_WRAP   = 1'b0,
    localparam int IW      = (N_BALLS > 1) ? $clog2(N_BALLS) : 1
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_ani_stb,
    input  logic                 i_animate,
    input  logic                 i_clear,
    input  logic                 i_load_vld,
    output logic                 o_load_rdy,
    input  logic [IW-1:0]        i_load_idx,
    input  logic [W-1:0]         i_load_cx,
    input  logic [W-1:0]         i_load_cy,
    input  logic [VW-1:0]        i_load_vx,
    input  logic [VW-1:0]        i_load_vy,
    input  logic [W-1:0]         i_hx,
    input  logic [W-1:0]         i_hy,
    input  logic [W-1:0]         i_hr,
    output logic [N_BALLS*W-1:0] o_cx,
    output logic [N_BALLS*W-1:0] o_cy,
    output logic [W-1:0]         o_r,
    output logic [N_BALLS-1:0]   o_active,
    output logic                 o_busy,
    output logic                 o_frame_done,
    output logic                 o_hit,
    output logic [N_BALLS-1:0]   o_hit_mask
);

    localparam int SW = W + 2;
    typedef logic signed [SW-1:0] sval_t;
    typedef logic signed [VW-1:0] vel_t;

    localparam sval_t         c_l    = sval_t'(FX + R);
    localparam sval_t         c_rt   = sval_t'(FX + F_WIDTH - R);
    localparam sval_t         c_t    = sval_t'(FY + R);
    localparam sval_t         c_b    = sval_t'(FY + F_HEIGHT - R);
    localparam sval_t         c_one  = sval_t'(1);
    localparam logic [W-1:0]  c_cx0  = W'(FX + F_WIDTH / 2);
    localparam logic [W-1:0]  c_cy0  = W'(FY + F_HEIGHT / 2);
    localparam logic [IW-1:0] c_last = IW'(N_BALLS - 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SWEEP = 1'b1
    } state_t;

    function automatic sval_t clamp(input sval_t v, input sval_t lo, input sval_t hi);
        sval_t r;
        r = v;
        if (v < lo) r = lo;
        else if (v > hi) r = hi;
        return r;
    endfunction

    // One axis of motion; the bounce velocity is forced toward the interior.
    function automatic void axis_step(input sval_t c, input vel_t v, input sval_t lo,
                                      input sval_t hi, input logic wrap,
                                      output sval_t nc, output vel_t nv);
        sval_t nx;
        vel_t  vabs;
        vabs = v[VW-1] ? -v : v;
        nx   = c + sval_t'(v);
        nc   = nx;
        nv   = v;
        if (wrap) begin
            if (nx < lo) nc = hi - (lo - nx - c_one);
            else if (nx > hi) nc = lo + (nx - hi - c_one);
            nc = clamp(nc, lo, hi);
        end else if (nx < lo) begin
            nc = lo;
            nv = vabs;
        end else if (nx > hi) begin
            nc = hi;
            nv = -vabs;
        end
    endfunction

    function automatic logic near(input sval_t a, input sval_t b, input sval_t lim);
        sval_t d;
        d = a - b;
        if (d[SW-1]) d = -d;
        return d < lim;
    endfunction

    state_t              r_state, w_state_next;
    logic [IW-1:0]       r_idx;
    logic [N_BALLS-1:0]  r_shadow, r_hit_mask, w_mask_next;
    logic                r_frame_done, r_hit;
    logic                w_last, w_load_fire, w_clear;

    logic [W-1:0]        w_cx_all  [N_BALLS];
    logic [W-1:0]        w_cy_all  [N_BALLS];
    vel_t                w_vx_all  [N_BALLS];
    vel_t                w_vy_all  [N_BALLS];
    logic                w_act_all [N_BALLS];

    sval_t               w_cx_cur, w_cy_cur, w_cx_new, w_cy_new, w_lim;
    sval_t               w_ld_cx_s, w_ld_cy_s;
    vel_t                w_vx_new, w_vy_new;
    logic                w_hit_cur;
    logic [W-1:0]        w_ld_cx, w_ld_cy;

    assign w_last      = (r_state == ST_SWEEP) && (r_idx == c_last);
    assign w_load_fire = i_load_vld && (r_state == ST_IDLE);
    assign w_clear     = i_clear && (r_state == ST_IDLE);

    // Datapath for the ball currently addressed by the sweep index.
    always_comb begin
        w_cx_cur  = sval_t'(w_cx_all[r_idx]);
        w_cy_cur  = sval_t'(w_cy_all[r_idx]);
        w_cx_new  = w_cx_cur;
        w_cy_new  = w_cy_cur;
        w_vx_new  = w_vx_all[r_idx];
        w_vy_new  = w_vy_all[r_idx];
        axis_step(w_cx_cur, w_vx_all[r_idx], c_l, c_rt, X_WRAP, w_cx_new, w_vx_new);
        axis_step(w_cy_cur, w_vy_all[r_idx], c_t, c_b, Y_WRAP, w_cy_new, w_vy_new);
        w_lim     = sval_t'(R) + sval_t'(i_hr);
        w_hit_cur = w_act_all[r_idx]
                  & near(w_cx_new, sval_t'(i_hx), w_lim)
                  & near(w_cy_new, sval_t'(i_hy), w_lim);
        w_ld_cx_s = clamp(sval_t'(i_load_cx), c_l, c_rt);
        w_ld_cy_s = clamp(sval_t'(i_load_cy), c_t, c_b);
        w_ld_cx   = w_ld_cx_s[W-1:0];
        w_ld_cy   = w_ld_cy_s[W-1:0];
    end

    for (genvar k = 0; k < N_BALLS; k++) begin : g_ball
        logic [W-1:0] r_cx, r_cy;
        vel_t         r_vx, r_vy;
        logic         r_active;
        logic         w_sel_ld, w_sel_sw;

        // An out-of-range load index matches no ball and is silently dropped.
        assign w_sel_ld = w_load_fire && (i_load_idx == IW'(k));
        assign w_sel_sw = (r_state == ST_SWEEP) && (r_idx == IW'(k)) && r_active;

        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                r_cx     <= c_cx0;
                r_cy     <= c_cy0;
                r_vx     <= '0;
                r_vy     <= '0;
                r_active <= 1'b0;
            end else if (w_sel_ld) begin
                r_active <= 1'b1;
                r_cx     <= w_ld_cx;
                r_cy     <= w_ld_cy;
                r_vx     <= i_load_vx;
                r_vy     <= i_load_vy;
            end else if (w_clear) begin
                r_active <= 1'b0;
            end else if (w_sel_sw) begin
                r_cx     <= w_cx_new[W-1:0];
                r_cy     <= w_cy_new[W-1:0];
                r_vx     <= w_vx_new;
                r_vy     <= w_vy_new;
            end
        end

        assign w_cx_all[k]  = r_cx;
        assign w_cy_all[k]  = r_cy;
        assign w_vx_all[k]  = r_vx;
        assign w_vy_all[k]  = r_vy;
        assign w_act_all[k] = r_active;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  if (i_ani_stb && i_animate) w_state_next = ST_SWEEP;
            ST_SWEEP: if (r_idx == c_last) w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_mask_next = r_shadow;
        for (int k = 0; k < N_BALLS; k++) begin
            if (r_idx == IW'(k)) w_mask_next[k] = w_hit_cur;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= ST_IDLE;
            r_idx        <= '0;
            r_shadow     <= '0;
            r_hit_mask   <= '0;
            r_frame_done <= 1'b0;
            r_hit        <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_frame_done <= w_last;
            r_hit        <= w_last && (|w_mask_next);
            if (r_state == ST_IDLE) begin
                r_idx    <= '0;
                r_shadow <= '0;
            end else begin
                r_idx    <= r_idx + 1'b1;
                r_shadow <= w_mask_next;
            end
            if (w_last) r_hit_mask <= w_mask_next;
        end
    end

    always_comb begin
        o_cx     = '0;
        o_cy     = '0;
        o_active = '0;
        for (int k = 0; k < N_BALLS; k++) begin
            o_cx[k*W +: W] = w_cx_all[k];
            o_cy[k*W +: W] = w_cy_all[k];
            o_active[k]    = w_act_all[k];
        end
    end

    assign o_load_rdy   = (r_state == ST_IDLE);
    assign o_busy       = (r_state == ST_SWEEP);
    assign o_r          = W'(R);
    assign o_frame_done = r_frame_done;
    assign o_hit        = r_hit;
    assign o_hit_mask   = r_hit_mask;

endmodule
`default_nettype wire

// File: tb/tb_ball_swarm.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ball_swarm
//  Description : Scoreboard bench; a bounce DUT (4 balls) and a wrap DUT
//                (3 balls) share one stimulus stream.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ball_swarm;

    typedef struct {
        logic [63:0] cx;
        logic [63:0] cy;
        logic [3:0]  act;
        logic [3:0]  mask;
        logic        hit;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n, ani_stb, animate, clear, load_vld;
    logic [1:0]  load_idx;
    logic [15:0] load_cx, load_cy, hx, hy, hr;
    logic [3:0]  load_vx, load_vy;

    logic        a_rdy, a_busy, a_fd, a_hit;
    logic [63:0] a_cx, a_cy;
    logic [15:0] a_r;
    logic [3:0]  a_active, a_mask;
    logic        b_rdy, b_busy, b_fd, b_hit;
    logic [47:0] b_cx, b_cy;
    logic [15:0] b_r;
    logic [2:0]  b_active, b_mask;

    int   n_checks = 0;
    int   n_errors = 0;
    exp_t qa[$];
    exp_t qb[$];
    exp_t ea, eb;

    int   mcx [2][4];
    int   mcy [2][4];
    int   mvx [2][4];
    int   mvy [2][4];
    bit   mact[2][4];

    always #5 clk = ~clk;

    ball_swarm #(.N_BALLS(4)) u_dut_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_ani_stb(ani_stb), .i_animate(animate),
        .i_clear(clear), .i_load_vld(load_vld), .o_load_rdy(a_rdy), .i_load_idx(load_idx),
        .i_load_cx(load_cx), .i_load_cy(load_cy), .i_load_vx(load_vx), .i_load_vy(load_vy),
        .i_hx(hx), .i_hy(hy), .i_hr(hr), .o_cx(a_cx), .o_cy(a_cy), .o_r(a_r),
        .o_active(a_active), .o_busy(a_busy), .o_frame_done(a_fd), .o_hit(a_hit),
        .o_hit_mask(a_mask)
    );

    ball_swarm #(.N_BALLS(3), .X_WRAP(1'b1), .Y_WRAP(1'b1)) u_dut_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_ani_stb(ani_stb), .i_animate(animate),
        .i_clear(clear), .i_load_vld(load_vld), .o_load_rdy(b_rdy), .i_load_idx(load_idx),
        .i_load_cx(load_cx), .i_load_cy(load_cy), .i_load_vx(load_vx), .i_load_vy(load_vy),
        .i_hx(hx), .i_hy(hy), .i_hr(hr), .o_cx(b_cx), .o_cy(b_cy), .o_r(b_r),
        .o_active(b_active), .o_busy(b_busy), .o_frame_done(b_fd), .o_hit(b_hit),
        .o_hit_mask(b_mask)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int nball(input int d);
        return (d == 0) ? 4 : 3;
    endfunction

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic int iclamp(input int v, input int lo, input int hi);
        return (v < lo) ? lo : ((v > hi) ? hi : v);
    endfunction

    function automatic void m_axis(input int c, input int v, input int lo, input int hi,
                                   input bit wr, output int nc, output int nv);
        int nx;
        nx = c + v;
        nc = nx;
        nv = v;
        if (wr) begin
            if (nx < lo) nc = hi - (lo - nx - 1);
            else if (nx > hi) nc = lo + (nx - hi - 1);
            nc = iclamp(nc, lo, hi);
        end else if (nx < lo) begin
            nc = lo;
            nv = iabs(v);
        end else if (nx > hi) begin
            nc = hi;
            nv = -iabs(v);
        end
    endfunction

    function automatic void m_reset();
        for (int d = 0; d < 2; d++)
            for (int k = 0; k < 4; k++) begin
                mcx[d][k] = 320; mcy[d][k] = 305;
                mvx[d][k] = 0;   mvy[d][k] = 0;
                mact[d][k] = 1'b0;
            end
    endfunction

    function automatic void m_clear();
        for (int d = 0; d < 2; d++)
            for (int k = 0; k < 4; k++) mact[d][k] = 1'b0;
    endfunction

    function automatic void m_load(input int idx, input int cx, input int cy,
                                   input int vx, input int vy);
        for (int d = 0; d < 2; d++) begin
            if (idx < nball(d)) begin
                mact[d][idx] = 1'b1;
                mcx[d][idx]  = iclamp(cx, 250, 390);
                mcy[d][idx]  = iclamp(cy, 235, 375);
                mvx[d][idx]  = vx;
                mvy[d][idx]  = vy;
            end
        end
    endfunction

    function automatic void m_frame();
        exp_t e;
        int   nc, nv, lim;
        lim = 5 + int'(hr);
        for (int d = 0; d < 2; d++) begin
            e.cx = '0; e.cy = '0; e.act = '0; e.mask = '0;
            for (int k = 0; k < nball(d); k++) begin
                if (mact[d][k]) begin
                    m_axis(mcx[d][k], mvx[d][k], 250, 390, d == 1, nc, nv);
                    mcx[d][k] = nc; mvx[d][k] = nv;
                    m_axis(mcy[d][k], mvy[d][k], 235, 375, d == 1, nc, nv);
                    mcy[d][k] = nc; mvy[d][k] = nv;
                    if (iabs(mcx[d][k] - int'(hx)) < lim && iabs(mcy[d][k] - int'(hy)) < lim)
                        e.mask[k] = 1'b1;
                end
                e.cx[k*16 +: 16] = 16'(mcx[d][k]);
                e.cy[k*16 +: 16] = 16'(mcy[d][k]);
                e.act[k]         = mact[d][k];
            end
            e.hit = |e.mask;
            if (d == 0) qa.push_back(e);
            else        qb.push_back(e);
        end
    endfunction

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (a_fd) begin
            if (qa.size() == 0) check("a_unexpected_frame_done", 1, 0);
            else begin
                ea = qa.pop_front();
                check("a_cx", a_cx, ea.cx);
                check("a_cy", a_cy, ea.cy);
                check("a_active", a_active, ea.act);
                check("a_hit_mask", a_mask, ea.mask);
                check("a_hit", a_hit, ea.hit);
            end
        end else if (a_hit) check("a_hit_without_frame_done", a_hit, 0);
        if (b_fd) begin
            if (qb.size() == 0) check("b_unexpected_frame_done", 1, 0);
            else begin
                eb = qb.pop_front();
                check("b_cx", b_cx, eb.cx);
                check("b_cy", b_cy, eb.cy);
                check("b_active", b_active, eb.act);
                check("b_hit_mask", b_mask, eb.mask);
                check("b_hit", b_hit, eb.hit);
            end
        end else if (b_hit) check("b_hit_without_frame_done", b_hit, 0);
    end

    // ---------------- stimulus tasks ----------------
    task automatic drive_load(input int idx, input int cx, input int cy, input int vx, input int vy);
        load_idx = 2'(idx);
        load_cx  = 16'(cx);
        load_cy  = 16'(cy);
        load_vx  = 4'(vx);
        load_vy  = 4'(vy);
    endtask

    task automatic do_load(input int idx, input int cx, input int cy, input int vx, input int vy);
        @(negedge clk);
        load_vld = 1'b1;
        drive_load(idx, cx, cy, vx, vy);
        check("load_rdy_idle", {a_rdy, b_rdy}, 2'b11);
        m_load(idx, cx, cy, vx, vy);
        @(negedge clk);
        load_vld = 1'b0;
    endtask

    // Strobe once; optionally hold a load on the strobe cycle or inject
    // strobes/loads/clears while the sweep runs. Measures sweep length.
    task automatic frame(input bit anim, input bit noise, input bit with_ld);
        int na, nbb;
        @(negedge clk);
        ani_stb = 1'b1;
        animate = anim;
        if (with_ld) load_vld = 1'b1;
        if (anim) m_frame();
        @(negedge clk);
        ani_stb  = 1'b0;
        animate  = 1'b1;
        load_vld = 1'b0;
        na = 0;
        nbb = 0;
        for (int c = 0; c < 8; c++) begin
            if (noise && c < 2) begin
                ani_stb  = 1'b1;
                clear    = 1'b1;
                load_vld = 1'b1;
                drive_load(0, 260, 260, 1, 1);
                check("load_rdy_busy", {a_rdy, b_rdy}, 2'b00);
            end else if (noise && c == 2) begin
                ani_stb  = 1'b0;
                clear    = 1'b0;
                load_vld = 1'b0;
            end
            if (a_busy) na++;
            if (b_busy) nbb++;
            @(negedge clk);
        end
        check("a_sweep_len", na, anim ? 4 : 0);
        check("b_sweep_len", nbb, anim ? 3 : 0);
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_a_cx"}, a_cx, {4{16'd320}});
        check({tag, "_a_cy"}, a_cy, {4{16'd305}});
        check({tag, "_b_cx"}, b_cx, {3{16'd320}});
        check({tag, "_b_cy"}, b_cy, {3{16'd305}});
        check({tag, "_active"}, {a_active, b_active}, 7'd0);
        check({tag, "_flags"}, {a_busy, a_fd, a_hit, a_mask, b_busy, b_fd, b_hit, b_mask}, 13'd0);
        check({tag, "_r"}, {a_r, b_r}, {16'd5, 16'd5});
        check({tag, "_rdy"}, {a_rdy, b_rdy}, 2'b11);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; ani_stb = 1'b0; animate = 1'b1; clear = 1'b0; load_vld = 1'b0;
        drive_load(0, 0, 0, 0, 0);
        hx = 16'd0; hy = 16'd0; hr = 16'd0;
        m_reset();
        repeat (3) @(negedge clk);
        check_reset("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // basic motion
        do_load(0, 300, 300, 3, -2);
        frame(1'b1, 1'b0, 1'b0);
        // right edge: bounce vs wrap, then follow-up frame
        do_load(0, 389, 300, 3, 0);
        frame(1'b1, 1'b0, 1'b0);
        frame(1'b1, 1'b0, 1'b0);
        // left and top edges
        do_load(0, 251, 236, -3, -3);
        frame(1'b1, 1'b0, 1'b0);
        frame(1'b1, 1'b0, 1'b0);

        // clear coinciding with a load: only the loaded ball remains active
        hx = 16'd300; hy = 16'd300; hr = 16'd8;
        @(negedge clk);
        clear = 1'b1; load_vld = 1'b1;
        drive_load(1, 310, 300, 0, 0);
        m_clear();
        m_load(1, 310, 300, 0, 0);
        @(negedge clk);
        clear = 1'b0; load_vld = 1'b0;
        check("clear_load_active", {a_active, b_active}, {4'b0010, 3'b010});
        frame(1'b1, 1'b0, 1'b0);
        do_load(1, 313, 300, 0, 0);
        frame(1'b1, 1'b0, 1'b0);
        do_load(1, 312, 300, 0, 0);
        frame(1'b1, 1'b0, 1'b0);

        // animate low: strobe ignored
        frame(1'b0, 1'b0, 1'b0);
        // strobes/loads/clears during a sweep are ignored
        frame(1'b1, 1'b1, 1'b0);
        // index 3 valid for the 4-ball DUT, out of range for the 3-ball DUT
        do_load(3, 280, 280, 1, 1);
        frame(1'b1, 1'b0, 1'b0);
        // load on the strobe cycle; out-of-box position is clamped on load
        drive_load(2, 400, 200, 5, 5);
        m_load(2, 400, 200, 5, 5);
        frame(1'b1, 1'b0, 1'b1);

        for (int i = 0; i < 8; i++) begin
            hx = 16'($urandom_range(250, 390));
            hy = 16'($urandom_range(235, 375));
            hr = 16'($urandom_range(0, 30));
            do_load(int'($urandom_range(0, 3)), int'($urandom_range(240, 400)),
                    int'($urandom_range(225, 385)), int'($urandom_range(0, 14)) - 7,
                    int'($urandom_range(0, 14)) - 7);
            frame(1'b1, 1'b0, 1'b0);
        end

        // reset in the middle of a sweep
        @(negedge clk);
        ani_stb = 1'b1;
        m_frame();
        @(negedge clk);
        ani_stb = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        m_reset();
        qa.delete();
        qb.delete();
        #1;
        check_reset("midsweep_reset");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        check_reset("after_reset");

        check("a_frames_outstanding", qa.size(), 0);
        check("b_frames_outstanding", qb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
